// File: rtl/fpu_fclass_pipe.sv
// Two-stage FCLASS.S pipeline.
// Stage 1 unpacks a single-precision operand into class flags.
// Stage 2 turns the flags into a one-hot class mask and presents it for integer writeback.
// Both stages use a valid/ready handshake, so the unit sustains one result per cycle.

// One-hot class mask from pre-decoded operand flags.
module fpu_classifier (
    input  logic       i_sign,
    input  logic       i_zero,
    input  logic       i_sub,
    input  logic       i_inf,
    input  logic       i_nan,
    input  logic       i_snan,
    output logic [9:0] o_mask
);

    logic w_normal;

    // An operand that is none of the special encodings is a normal number.
    assign w_normal = !(i_zero | i_sub | i_inf | i_nan);

    // Each class bit is one flag qualified by the sign.
    // NaNs ignore the sign and split on the quiet bit.
    always_comb begin
        o_mask    = 10'd0;
        o_mask[0] =  i_sign & i_inf;
        o_mask[1] =  i_sign & w_normal;
        o_mask[2] =  i_sign & i_sub;
        o_mask[3] =  i_sign & i_zero;
        o_mask[4] = !i_sign & i_zero;
        o_mask[5] = !i_sign & i_sub;
        o_mask[6] = !i_sign & w_normal;
        o_mask[7] = !i_sign & i_inf;
        o_mask[8] =  i_nan  & i_snan;
        o_mask[9] =  i_nan  & !i_snan;
    end

endmodule

module fpu_fclass_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      operand_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    // Operand fields.
    logic [7:0]       w_exp;
    logic [22:0]      w_man;
    logic             w_exp_zero;
    logic             w_exp_ones;
    logic             w_man_zero;

    // Stage-1 decode, before the register.
    logic             w_dec_zero;
    logic             w_dec_sub;
    logic             w_dec_inf;
    logic             w_dec_nan;
    logic             w_dec_snan;

    // Handshake.
    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_in_fire;
    logic             w_s1_advance;

    // Stage-1 registers.
    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_zero;
    logic             r_s1_sub;
    logic             r_s1_inf;
    logic             r_s1_nan;
    logic             r_s1_snan;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage-2 registers.
    logic             r_s2_valid;
    logic [9:0]       r_s2_mask;
    logic [TAG_W-1:0] r_s2_tag;

    // Classifier output.
    logic [9:0]       w_mask;

    assign w_exp      = operand_i[30:23];
    assign w_man      = operand_i[22:0];
    assign w_exp_zero = (w_exp == 8'h00);
    assign w_exp_ones = (w_exp == 8'hFF);
    assign w_man_zero = (w_man == 23'd0);

    // The flags are mutually exclusive, except that snan is a subset of nan.
    // A NaN is signalling when the quiet bit (mantissa MSB) is clear.
    always_comb begin
        w_dec_zero = w_exp_zero & w_man_zero;
        w_dec_sub  = w_exp_zero & !w_man_zero;
        w_dec_inf  = w_exp_ones & w_man_zero;
        w_dec_nan  = w_exp_ones & !w_man_zero;
        w_dec_snan = w_dec_nan & !w_man[22];
    end

    // A stage can take a new entry if it is empty or its entry leaves this cycle.
    // in_ready_o depends only on pipeline state and out_ready_i, never on in_valid_i.
    assign w_s2_ready   = !r_s2_valid | out_ready_i;
    assign w_s1_ready   = !r_s1_valid | w_s2_ready;
    assign in_ready_o   = w_s1_ready;
    assign w_in_fire    = in_valid_i & w_s1_ready;
    assign w_s1_advance = r_s1_valid & w_s2_ready;

    // Stage-1 occupancy.
    // Flush wins over everything and drops any input presented in the same cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1_valid <= 1'b0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid_i;
        end
    end

    // Stage-1 flags and tag.
    // These load only on an accepted input and are left alone by flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1_sign <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_sub  <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_nan  <= 1'b0;
            r_s1_snan <= 1'b0;
            r_s1_tag  <= '0;
        end else if (w_in_fire) begin
            r_s1_sign <= operand_i[31];
            r_s1_zero <= w_dec_zero;
            r_s1_sub  <= w_dec_sub;
            r_s1_inf  <= w_dec_inf;
            r_s1_nan  <= w_dec_nan;
            r_s1_snan <= w_dec_snan;
            r_s1_tag  <= tag_i;
        end
    end

    fpu_classifier u_classifier (
        .i_sign (r_s1_sign),
        .i_zero (r_s1_zero),
        .i_sub  (r_s1_sub),
        .i_inf  (r_s1_inf),
        .i_nan  (r_s1_nan),
        .i_snan (r_s1_snan),
        .o_mask (w_mask)
    );

    // Stage-2 occupancy.
    // The stage refills from stage 1 whenever its current result is consumed or it is empty.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s2_valid <= 1'b0;
        end else if (flush_i) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    // Stage-2 mask and tag.
    // These hold while the consumer stalls, so result_o and tag_o stay stable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s2_mask <= 10'd0;
            r_s2_tag  <= '0;
        end else if (w_s1_advance) begin
            r_s2_mask <= w_mask;
            r_s2_tag  <= r_s1_tag;
        end
    end

    assign out_valid_o = r_s2_valid;
    assign result_o    = {{(XLEN-10){1'b0}}, r_s2_mask};
    assign tag_o       = r_s2_tag;

endmodule

// File: tb/tb_fpu_fclass_pipe.sv
// Self-checking bench for fpu_fclass_pipe.
// An always-running monitor keeps a queue of in-flight operands.
// For each operand it stores the cycle it was accepted and its class mask, computed from the IEEE-754 rules.
// The monitor checks out_valid_o, in_ready_o, result_o and tag_o against that queue.
// The scenario tasks add targeted checks against fixed constants.
module tb_fpu_fclass_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk_i;
    logic             reset_i;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      operand_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    typedef struct {
        int               acc;
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } item_t;

    item_t            model[$];
    logic [XLEN-1:0]  seenRes[$];
    logic [TAG_W-1:0] seenTag[$];
    int               cyc      = 0;
    int               outCount = 0;
    int               checks   = 0;
    int               errors   = 0;

    fpu_fclass_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_i   (operand_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    // 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Cycle counter used to age entries in the model.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference classification.
    // Picks the class index from the exponent and mantissa values, then returns a one-hot mask.
    function automatic logic [XLEN-1:0] refClass(input logic [31:0] x);
        int  e;
        int  m;
        bit  neg;
        int  idx;
        e   = int'(x[30:23]);
        m   = int'(x[22:0]);
        neg = x[31];
        if (e == 255) begin
            if (m == 0) idx = neg ? 0 : 7;
            else        idx = (m >= (1 << 22)) ? 9 : 8;
        end else if (e == 0) begin
            if (m == 0) idx = neg ? 3 : 4;
            else        idx = neg ? 2 : 5;
        end else begin
            idx = neg ? 1 : 6;
        end
        return XLEN'(1) << idx;
    endfunction

    // Monitor, sampled on the falling edge.
    // The oldest in-flight entry must be visible once it is at least two cycles old.
    // The unit is full only when two entries are in flight and the consumer stalls.
    always @(negedge clk_i) begin
        logic expValid;
        logic expReady;
        item_t it;
        if (reset_i) begin
            model.delete();
        end else begin
            expValid = (model.size() > 0) && ((cyc - model[0].acc) >= 2);
            expReady = !((model.size() == 2) && !out_ready_i);
            checks++;
            if (out_valid_o !== expValid) begin
                errors++;
                $display("[TB] FAIL mon_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, expValid);
            end
            checks++;
            if (in_ready_o !== expReady) begin
                errors++;
                $display("[TB] FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready_o, expReady);
            end
            if (expValid && out_valid_o) begin
                checks++;
                if (result_o !== model[0].res) begin
                    errors++;
                    $display("[TB] FAIL mon_result cyc=%0d got=%h exp=%h", cyc, result_o, model[0].res);
                end
                checks++;
                if (tag_o !== model[0].tag) begin
                    errors++;
                    $display("[TB] FAIL mon_tag cyc=%0d got=%0d exp=%0d", cyc, tag_o, model[0].tag);
                end
            end
            if (flush_i) begin
                model.delete();
            end else begin
                if (expValid && out_valid_o && out_ready_i) begin
                    seenRes.push_back(result_o);
                    seenTag.push_back(tag_o);
                    void'(model.pop_front());
                    outCount++;
                end
                if (in_valid_i && in_ready_o) begin
                    it.acc = cyc;
                    it.res = refClass(operand_i);
                    it.tag = tag_i;
                    model.push_back(it);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    // Checks the outputs while reset is held and right after it is released.
    task automatic test_reset();
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        operand_i   = '0;
        tag_i       = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid_o); end
        checks++;
        if (result_o !== '0) begin errors++; $display("[TB] FAIL rst_result got=%h exp=0", result_o); end
        checks++;
        if (tag_o !== '0) begin errors++; $display("[TB] FAIL rst_tag got=%h exp=0", tag_o); end
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready_held got=%b exp=1", in_ready_o); end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready_after got=%b exp=1", in_ready_o); end
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid_after got=%b exp=0", out_valid_o); end
    endtask

    // Streams one operand per class back-to-back and checks the fixed masks and tags.
    task automatic test_stream();
        logic [31:0] ops [10];
        ops = '{32'hFF800000, 32'hBF800000, 32'h80000001, 32'h80000000, 32'h00000000,
                32'h00000001, 32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000};
        seenRes.delete();
        seenTag.delete();
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            in_valid_i = 1'b1;
            operand_i  = ops[i];
            tag_i      = TAG_W'(i);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (seenRes.size() != 10) begin
            errors++;
            $display("[TB] FAIL stream_count got=%0d exp=10", seenRes.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (seenRes[i] !== (XLEN'(1) << i)) begin
                    errors++;
                    $display("[TB] FAIL stream_result[%0d] got=%h exp=%h", i, seenRes[i], XLEN'(1) << i);
                end
                checks++;
                if (seenTag[i] !== TAG_W'(i)) begin
                    errors++;
                    $display("[TB] FAIL stream_tag[%0d] got=%0d exp=%0d", i, seenTag[i], i);
                end
            end
        end
    endtask

    // Stalls the consumer for four cycles while presenting three operands.
    task automatic test_stall();
        logic [XLEN-1:0] held;
        seenRes.delete();
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; operand_i = 32'hC0000000; tag_i = 5'd11;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_a got=%b exp=1", in_ready_o); end
        @(posedge clk_i); #1;
        operand_i = 32'h00400000; tag_i = 5'd12;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_b got=%b exp=1", in_ready_o); end
        @(posedge clk_i); #1;
        operand_i = 32'hFF800000; tag_i = 5'd13;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_c got=%b exp=0", in_ready_o); end
        held = result_o;
        checks++;
        if (held !== 32'h002) begin errors++; $display("[TB] FAIL stall_head got=%h exp=002", held); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (result_o !== held) begin errors++; $display("[TB] FAIL stall_stable got=%h exp=%h", result_o, held); end
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_c2 got=%b exp=0", in_ready_o); end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready got=%b exp=1", in_ready_o); end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (seenRes.size() != 3) begin
            errors++;
            $display("[TB] FAIL stall_count got=%0d exp=3", seenRes.size());
        end else begin
            checks++;
            if (seenRes[0] !== 32'h002 || seenRes[1] !== 32'h020 || seenRes[2] !== 32'h001) begin
                errors++;
                $display("[TB] FAIL stall_order got=%h,%h,%h exp=002,020,001", seenRes[0], seenRes[1], seenRes[2]);
            end
        end
    endtask

    // Flushes with two entries in flight and a third operand presented.
    task automatic test_flush();
        int n0;
        n0 = outCount;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; operand_i = 32'h3F800000; tag_i = 5'd21;
        @(posedge clk_i); #1;
        operand_i = 32'h7F800000; tag_i = 5'd22;
        @(posedge clk_i); #1;
        operand_i = 32'h00000000; tag_i = 5'd23;
        flush_i   = 1'b1;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid got=%b exp=0", out_valid_o); end
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (outCount != n0) begin errors++; $display("[TB] FAIL flush_no_output got=%0d exp=%0d", outCount, n0); end
    endtask

    // Asserts reset between edges with a full pipeline, then sends one sNaN operand.
    task automatic test_async_reset();
        int n0;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; operand_i = 32'hBF800000; tag_i = 5'd3;
        @(posedge clk_i); #1;
        operand_i = 32'h80000000; tag_i = 5'd4;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_out_valid got=%b exp=0", out_valid_o); end
        checks++;
        if (result_o !== '0) begin errors++; $display("[TB] FAIL areset_result got=%h exp=0", result_o); end
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL areset_in_ready got=%b exp=1", in_ready_o); end
        @(negedge clk_i); #1;
        reset_i     = 1'b0;
        out_ready_i = 1'b1;
        n0 = outCount;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; operand_i = 32'h7FBFFFFF; tag_i = 5'd7;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h100 || tag_o !== 5'd7) begin
            errors++;
            $display("[TB] FAIL areset_snan got=v%b r%h t%0d exp=v1 r100 t7", out_valid_o, result_o, tag_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (outCount != n0 + 1) begin errors++; $display("[TB] FAIL areset_count got=%0d exp=%0d", outCount, n0 + 1); end
    endtask

    // NaN payload and subnormal edge cases.
    task automatic test_edge_nan();
        logic [31:0] ops [3];
        ops = '{32'hFFFFFFFF, 32'hFF800001, 32'h807FFFFF};
        seenRes.delete();
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            in_valid_i = 1'b1;
            operand_i  = ops[i];
            tag_i      = TAG_W'(i + 16);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (seenRes.size() != 3) begin
            errors++;
            $display("[TB] FAIL edge_count got=%0d exp=3", seenRes.size());
        end else begin
            checks++;
            if (seenRes[0] !== 32'h200) begin errors++; $display("[TB] FAIL edge_qnan got=%h exp=200", seenRes[0]); end
            checks++;
            if (seenRes[1] !== 32'h100) begin errors++; $display("[TB] FAIL edge_snan got=%h exp=100", seenRes[1]); end
            checks++;
            if (seenRes[2] !== 32'h004) begin errors++; $display("[TB] FAIL edge_negsub got=%h exp=004", seenRes[2]); end
        end
    endtask

    // Random valid, ready, rare flush and class-biased operands, all checked by the monitor.
    task automatic test_random();
        logic [31:0] op;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i); #1;
            op = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: op[30:23] = 8'h00;
                2: op[30:23] = 8'hFF;
                default: begin
                    op[22:0]  = '0;
                    op[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                end
            endcase
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 24) == 0);
            operand_i   = op;
            tag_i       = TAG_W'($urandom);
        end
        @(posedge clk_i); #1;
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (model.size() != 0) begin errors++; $display("[TB] FAIL random_drain got=%0d exp=0", model.size()); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_edge_nan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
